simon_control: RTL and testbench
================================

SIMON_CONTROL -- requirements
Module: simon_control

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset; one clock, no other clock domains.
REQ-003 index_lt_count  input  1  datapath flag: playback index < stored pattern count.
REQ-004 input_eq_pattern  input  1  datapath flag: switch pattern equals memory word at index.
REQ-005 is_legal  input  1  datapath flag: switch pattern legal for the latched level.
REQ-006 w_en  output  1  write switch pattern to memory at address = count.
REQ-007 set_level  output  1  latch level switch into datapath.
REQ-008 read_Memory  output  1  1: LEDs show memory word; 0: LEDs show switch pattern.
REQ-009 cnt_count / clr_count  output  1 each  increment / clear datapath count.
REQ-010 cnt_index / clr_index  output  1 each  increment / clear datapath index.
REQ-011 mode_leds  output  3  registered mode: INPUT 001, PLAYBACK 010, REPEAT 100, DONE 111, INIT 000.

Function
REQ-012 States SHALL be INIT, INPUT, PLAYBACK, REPEAT, DONE; binary-encoded register, Moore mode_leds, Mealy control outputs (combinational from state and flags).
REQ-013 Control outputs not listed for a state/condition SHALL be 0.
REQ-014 INIT: set_level=1, clr_count=1, clr_index=1; next state INPUT unconditionally.
REQ-015 INPUT, is_legal=1: w_en=1, cnt_count=1, clr_index=1; next PLAYBACK; round counter +1.
REQ-016 INPUT, is_legal=0: no outputs asserted; remain INPUT.
REQ-017 PLAYBACK: read_Memory=1 always; index_lt_count=1 -> cnt_index=1, remain; index_lt_count=0 -> clr_index=1, next REPEAT.
REQ-018 REPEAT: read_Memory=0; index_lt_count=1 and input_eq_pattern=1 -> cnt_index=1, remain.
REQ-019 REPEAT: index_lt_count=1 and input_eq_pattern=0 -> clr_index=1, next DONE (mismatch = loss).
REQ-020 REPEAT: index_lt_count=0 -> clr_index=1, next INPUT (round complete); input_eq_pattern ignored.
REQ-021 DONE: read_Memory=1; index_lt_count=1 -> cnt_index=1; index_lt_count=0 -> clr_index=1 (loop playback, wrap to 0); remain DONE until rst.
REQ-022 Flags SHALL be sampled only at rising clk; mode_leds SHALL change on the same edge as the state register.
REQ-023 set_level SHALL be asserted only in INIT; level is frozen for the game.
REQ-024 w_en and cnt_count SHALL always assert together, never in any state but INPUT.
REQ-025 clr_index and cnt_index SHALL never assert in the same cycle.

Reset
REQ-026 rst=1 SHALL force state=INIT, mode_leds=000, round counter=0 asynchronously, regardless of clk.
REQ-027 While rst=1, outputs SHALL equal the INIT decode (set_level, clr_count, clr_index = 1; others 0).
REQ-028 Reset asserted mid-PLAYBACK/REPEAT/DONE SHALL abandon the game; first edge after release enters INPUT with datapath cleared.

Configuration
REQ-029 Macro SIMON_WIN_LIMIT_EN: defined -> 7-bit round counter present; REPEAT completion (REQ-020) with counter=64 goes to DONE instead of INPUT (memory full = win).
REQ-030 SIMON_WIN_LIMIT_EN undefined -> no round counter; REQ-020 always returns to INPUT; count wraps in datapath.

Verification
REQ-031 rst pulse mid-REPEAT -> immediate mode_leds=000, clr_count=clr_index=set_level=1; one clk later mode_leds=001.
REQ-032 INPUT, is_legal=0 for 3 clks -> state INPUT, w_en=0 throughout; then is_legal=1 -> w_en=cnt_count=1 that cycle, mode_leds=010 after edge.
REQ-033 count=2: PLAYBACK with index_lt_count 1,1,0 -> cnt_index on first two edges, clr_index on third, mode_leds=100.
REQ-034 REPEAT count=2, input_eq_pattern=1,1 then index_lt_count=0 -> cnt_index twice, clr_index, mode_leds=001.
REQ-035 REPEAT, input_eq_pattern=0 at index 1 -> clr_index=1, mode_leds=111; DONE loops cnt_index/clr_index with read_Memory=1.
REQ-036 SIMON_WIN_LIMIT_EN defined, 64 successful rounds -> 64th REPEAT completion enters DONE (111); undefined -> enters INPUT (001).

Source files
------------

// File: rtl/simon_control.sv
`default_nettype none
// ============================================================================
// Module      : simon_control
// Description : Simon game controller FSM. Moore mode LEDs, Mealy datapath
//               controls. Optional macro SIMON_WIN_LIMIT_EN adds a win limit.
// Revision    : 1.0 - initial release
// ============================================================================
module simon_control (
    input  logic       clk,
    input  logic       rst,
    input  logic       index_lt_count,
    input  logic       input_eq_pattern,
    input  logic       is_legal,
    output logic       w_en,
    output logic       set_level,
    output logic       read_Memory,
    output logic       cnt_count,
    output logic       clr_count,
    output logic       cnt_index,
    output logic       clr_index,
    output logic [2:0] mode_leds
);

    localparam logic [2:0] c_st_init     = 3'd0;
    localparam logic [2:0] c_st_input    = 3'd1;
    localparam logic [2:0] c_st_playback = 3'd2;
    localparam logic [2:0] c_st_repeat   = 3'd3;
    localparam logic [2:0] c_st_done     = 3'd4;

    localparam logic [2:0] c_led_init     = 3'b000;
    localparam logic [2:0] c_led_input    = 3'b001;
    localparam logic [2:0] c_led_playback = 3'b010;
    localparam logic [2:0] c_led_repeat   = 3'b100;
    localparam logic [2:0] c_led_done     = 3'b111;

    logic [2:0] r_state;
    logic [2:0] w_next_state;
    logic [2:0] r_mode_leds;
    logic [2:0] w_next_leds;
    logic       w_win;

`ifdef SIMON_WIN_LIMIT_EN
    // Counts rounds started; 64 rounds fill the pattern memory.
    logic [6:0] r_round;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_round <= 7'd0;
        end else if (r_state == c_st_input && is_legal) begin
            r_round <= r_round + 7'd1;
        end
    end

    assign w_win = (r_round == 7'd64);
`else
    assign w_win = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_init;
            r_mode_leds <= c_led_init;
        end else begin
            r_state     <= w_next_state;
            r_mode_leds <= w_next_leds;
        end
    end

    assign mode_leds = r_mode_leds;

    always_comb begin
        w_next_state = r_state;
        w_en         = 1'b0;
        set_level    = 1'b0;
        read_Memory  = 1'b0;
        cnt_count    = 1'b0;
        clr_count    = 1'b0;
        cnt_index    = 1'b0;
        clr_index    = 1'b0;
        case (r_state)
            c_st_init: begin
                set_level    = 1'b1;
                clr_count    = 1'b1;
                clr_index    = 1'b1;
                w_next_state = c_st_input;
            end
            c_st_input: begin
                if (is_legal) begin
                    w_en         = 1'b1;
                    cnt_count    = 1'b1;
                    clr_index    = 1'b1;
                    w_next_state = c_st_playback;
                end
            end
            c_st_playback: begin
                read_Memory = 1'b1;
                if (index_lt_count) begin
                    cnt_index = 1'b1;
                end else begin
                    clr_index    = 1'b1;
                    w_next_state = c_st_repeat;
                end
            end
            c_st_repeat: begin
                if (index_lt_count && input_eq_pattern) begin
                    cnt_index = 1'b1;
                end else if (index_lt_count) begin
                    clr_index    = 1'b1;
                    w_next_state = c_st_done;
                end else begin
                    clr_index    = 1'b1;
                    w_next_state = w_win ? c_st_done : c_st_input;
                end
            end
            c_st_done: begin
                // Loops the stored pattern forever until reset.
                read_Memory = 1'b1;
                if (index_lt_count) begin
                    cnt_index = 1'b1;
                end else begin
                    clr_index = 1'b1;
                end
            end
            default: begin
                w_next_state = c_st_init;
            end
        endcase
    end

    always_comb begin
        case (w_next_state)
            c_st_input:    w_next_leds = c_led_input;
            c_st_playback: w_next_leds = c_led_playback;
            c_st_repeat:   w_next_leds = c_led_repeat;
            c_st_done:     w_next_leds = c_led_done;
            default:       w_next_leds = c_led_init;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_simon_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_simon_control
// Description : Directed self-checking bench for simon_control.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simon_control;

    logic       clk = 1'b0;
    logic       rst;
    logic       index_lt_count;
    logic       input_eq_pattern;
    logic       is_legal;
    logic       w_en, set_level, read_Memory, cnt_count, clr_count, cnt_index, clr_index;
    logic [2:0] mode_leds;
    logic [6:0] w_outs;

    int total = 0;
    int bad   = 0;

    // Output order: w_en set_level read_Memory cnt_count clr_count cnt_index clr_index
    localparam logic [6:0] c_o_init   = 7'b0100101;
    localparam logic [6:0] c_o_in_ok  = 7'b1001001;
    localparam logic [6:0] c_o_none   = 7'b0000000;
    localparam logic [6:0] c_o_mem_nx = 7'b0010010;
    localparam logic [6:0] c_o_mem_wr = 7'b0010001;
    localparam logic [6:0] c_o_rp_nx  = 7'b0000010;
    localparam logic [6:0] c_o_rp_clr = 7'b0000001;

    always #5 clk = ~clk;

    assign w_outs = {w_en, set_level, read_Memory, cnt_count, clr_count, cnt_index, clr_index};

    simon_control u_dut (
        .clk              (clk),
        .rst              (rst),
        .index_lt_count   (index_lt_count),
        .input_eq_pattern (input_eq_pattern),
        .is_legal         (is_legal),
        .w_en             (w_en),
        .set_level        (set_level),
        .read_Memory      (read_Memory),
        .cnt_count        (cnt_count),
        .clr_count        (clr_count),
        .cnt_index        (cnt_index),
        .clr_index        (clr_index),
        .mode_leds        (mode_leds)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; is_legal = 1'b0; index_lt_count = 1'b0; input_eq_pattern = 1'b0;
        step(); step();
        total++; if (mode_leds !== 3'b000) begin bad++; $display("FAIL reset_leds got=%b exp=000", mode_leds); end
        total++; if (w_outs !== c_o_init) begin bad++; $display("FAIL reset_outs got=%b exp=%b", w_outs, c_o_init); end
        rst = 1'b0;
        #1;
        total++; if (w_outs !== c_o_init) begin bad++; $display("FAIL init_outs got=%b exp=%b", w_outs, c_o_init); end
        step();
        total++; if (mode_leds !== 3'b001) begin bad++; $display("FAIL init_to_input got=%b exp=001", mode_leds); end
    endtask

    task automatic test_input;
        is_legal = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (w_outs !== c_o_none) begin bad++; $display("FAIL input_illegal_outs[%0d] got=%b exp=%b", i, w_outs, c_o_none); end
            step();
            total++; if (mode_leds !== 3'b001) begin bad++; $display("FAIL input_hold[%0d] got=%b exp=001", i, mode_leds); end
        end
        is_legal = 1'b1;
        #1;
        total++; if (w_outs !== c_o_in_ok) begin bad++; $display("FAIL input_legal_outs got=%b exp=%b", w_outs, c_o_in_ok); end
        step();
        is_legal = 1'b0;
        total++; if (mode_leds !== 3'b010) begin bad++; $display("FAIL input_to_playback got=%b exp=010", mode_leds); end
    endtask

    task automatic test_playback;
        for (int i = 0; i < 3; i++) begin
            index_lt_count = (i < 2);
            #1;
            if (i < 2) begin
                total++; if (w_outs !== c_o_mem_nx) begin bad++; $display("FAIL playback_cnt[%0d] got=%b exp=%b", i, w_outs, c_o_mem_nx); end
            end else begin
                total++; if (w_outs !== c_o_mem_wr) begin bad++; $display("FAIL playback_clr got=%b exp=%b", w_outs, c_o_mem_wr); end
            end
            step();
        end
        total++; if (mode_leds !== 3'b100) begin bad++; $display("FAIL playback_to_repeat got=%b exp=100", mode_leds); end
    endtask

    task automatic test_repeat_pass;
        input_eq_pattern = 1'b1;
        for (int i = 0; i < 2; i++) begin
            index_lt_count = 1'b1;
            #1;
            total++; if (w_outs !== c_o_rp_nx) begin bad++; $display("FAIL repeat_cnt[%0d] got=%b exp=%b", i, w_outs, c_o_rp_nx); end
            step();
            total++; if (mode_leds !== 3'b100) begin bad++; $display("FAIL repeat_hold[%0d] got=%b exp=100", i, mode_leds); end
        end
        index_lt_count = 1'b0;
        #1;
        total++; if (w_outs !== c_o_rp_clr) begin bad++; $display("FAIL repeat_done_outs got=%b exp=%b", w_outs, c_o_rp_clr); end
        step();
        input_eq_pattern = 1'b0;
        total++; if (mode_leds !== 3'b001) begin bad++; $display("FAIL repeat_to_input got=%b exp=001", mode_leds); end
    endtask

    task automatic test_repeat_fail;
        // Second round: INPUT -> PLAYBACK -> REPEAT, then miss at index 1.
        is_legal = 1'b1; step(); is_legal = 1'b0;
        index_lt_count = 1'b0; step();
        total++; if (mode_leds !== 3'b100) begin bad++; $display("FAIL fail_setup got=%b exp=100", mode_leds); end
        index_lt_count = 1'b1; input_eq_pattern = 1'b1; step();
        input_eq_pattern = 1'b0;
        #1;
        total++; if (w_outs !== c_o_rp_clr) begin bad++; $display("FAIL mismatch_outs got=%b exp=%b", w_outs, c_o_rp_clr); end
        step();
        total++; if (mode_leds !== 3'b111) begin bad++; $display("FAIL mismatch_to_done got=%b exp=111", mode_leds); end
        for (int i = 0; i < 4; i++) begin
            index_lt_count = (i != 2);
            #1;
            total++; if (w_outs !== (index_lt_count ? c_o_mem_nx : c_o_mem_wr)) begin bad++; $display("FAIL done_loop[%0d] got=%b", i, w_outs); end
            step();
            total++; if (mode_leds !== 3'b111) begin bad++; $display("FAIL done_hold[%0d] got=%b exp=111", i, mode_leds); end
        end
    endtask

    task automatic test_reset_mid;
        // Walk into REPEAT, then pulse reset away from a clock edge.
        rst = 1'b1; step(); rst = 1'b0; step();
        is_legal = 1'b1; step(); is_legal = 1'b0;
        index_lt_count = 1'b0; step();
        index_lt_count = 1'b1; input_eq_pattern = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        total++; if (mode_leds !== 3'b000) begin bad++; $display("FAIL async_reset_leds got=%b exp=000", mode_leds); end
        total++; if (w_outs !== c_o_init) begin bad++; $display("FAIL async_reset_outs got=%b exp=%b", w_outs, c_o_init); end
        step();
        rst = 1'b0; index_lt_count = 1'b0; input_eq_pattern = 1'b0;
        step();
        total++; if (mode_leds !== 3'b001) begin bad++; $display("FAIL reset_release got=%b exp=001", mode_leds); end
    endtask

    task automatic test_win_limit;
        logic [2:0] exp_last;
`ifdef SIMON_WIN_LIMIT_EN
        exp_last = 3'b111;
`else
        exp_last = 3'b001;
`endif
        rst = 1'b1; step(); rst = 1'b0; step();
        for (int r = 1; r <= 64; r++) begin
            is_legal = 1'b1; step(); is_legal = 1'b0;
            index_lt_count = 1'b0; step();
            #1;
            if (r == 64) begin
                total++; if (w_outs !== c_o_rp_clr) begin bad++; $display("FAIL win_repeat_outs got=%b exp=%b", w_outs, c_o_rp_clr); end
            end
            step();
            if (r < 64) begin
                total++; if (mode_leds !== 3'b001) begin bad++; $display("FAIL round_%0d got=%b exp=001", r, mode_leds); end
            end else begin
                total++; if (mode_leds !== exp_last) begin bad++; $display("FAIL round_64 got=%b exp=%b", mode_leds, exp_last); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_input();
        test_playback();
        test_repeat_pass();
        test_repeat_fail();
        test_reset_mid();
        test_win_limit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
